// File: rtl/watch_set_alarm.sv
// watch_set_alarm -- real-time watch time base with field adjust, 12/24-hour
// display and an hour:minute alarm.
//
// A prescaler divides clk down to TICK_HZ; each tick advances the chain
// msec -> sec -> min -> hour24. While set_en is high, single up/down pulses
// step one field (time or alarm) with wrap inside that field only. An adjust
// and a natural carry landing on the same field resolve in favour of the adjust.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   btnU_up/btnD_down one-cycle debounced step pulses
//   set_en            enables the buttons
//   target            0 = time registers, 1 = alarm registers
//   field             00 sec, 01 min, 10 hour, 11 none
//   h12               selects 12-hour mapping on the hour output
//   alarm_en          enables alarm_hit
//   msec/sec/min      running time
//   hour              display hour (0..23, or 1..12 when h12=1)
//   pm                internal hour24 >= 12
//   al_min/al_hour    alarm setting (24-hour)
//   alarm_hit         one-cycle pulse after the time chain rolls onto the alarm

module watch_set_alarm #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int DIV_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU_up,
  input  logic       btnD_down,
  input  logic       set_en,
  input  logic       target,
  input  logic [1:0] field,
  input  logic       h12,
  input  logic       alarm_en,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       pm,
  output logic [5:0] al_min,
  output logic [4:0] al_hour,
  output logic       alarm_hit
);

  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(CLK_HZ / TICK_HZ - 1);
  localparam logic [6:0]       MS_TOP  = 7'(TICK_HZ - 1);

  localparam logic [1:0] F_SEC  = 2'b00;
  localparam logic [1:0] F_MIN  = 2'b01;
  localparam logic [1:0] F_HOUR = 2'b10;
  localparam logic [1:0] F_NONE = 2'b11;

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [6:0]       msec_nxt;
  logic [5:0]       sec_nxt, min_nxt, al_min_nxt;
  logic [4:0]       hour24, hour24_nxt, al_hour_nxt;
  logic             fire;

  logic tick, ms_wrap, adj, adj_t, adj_a, step_up;
  logic c_sec, c_min;

  function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] top,
                                       input logic up);
    if (up) step6 = (v == top) ? 6'd0 : v + 6'd1;
    else    step6 = (v == 6'd0) ? top : v - 6'd1;
  endfunction

  function automatic logic [4:0] step5(input logic [4:0] v, input logic [4:0] top,
                                       input logic up);
    if (up) step5 = (v == top) ? 5'd0 : v + 5'd1;
    else    step5 = (v == 5'd0) ? top : v - 5'd1;
  endfunction

  assign tick    = (div_cnt == DIV_TOP);
  assign ms_wrap = tick && (msec == MS_TOP);

  // Exactly one button: pressing both together is treated as no request.
  assign adj     = set_en && (field != F_NONE) && (btnU_up ^ btnD_down);
  assign adj_t   = adj && !target;
  assign adj_a   = adj && target;
  assign step_up = btnU_up;

  always_comb begin
    div_nxt     = tick ? '0 : div_cnt + DIV_W'(1);
    msec_nxt    = msec;
    sec_nxt     = sec;
    min_nxt     = min;
    hour24_nxt  = hour24;
    al_min_nxt  = al_min;
    al_hour_nxt = al_hour;
    c_sec       = 1'b0;
    c_min       = 1'b0;

    if (tick) msec_nxt = ms_wrap ? 7'd0 : msec + 7'd1;

    // A field that is being adjusted takes the adjusted value and emits no
    // carry of its own, so the carry chain stops there.
    if (adj_t && field == F_SEC) begin
      sec_nxt  = step6(sec, 6'd59, step_up);
      msec_nxt = 7'd0;
      div_nxt  = '0;
    end else if (ms_wrap) begin
      sec_nxt = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
      c_sec   = (sec == 6'd59);
    end

    if (adj_t && field == F_MIN) begin
      min_nxt = step6(min, 6'd59, step_up);
    end else if (c_sec) begin
      min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
      c_min   = (min == 6'd59);
    end

    if (adj_t && field == F_HOUR) begin
      hour24_nxt = step5(hour24, 5'd23, step_up);
    end else if (c_min) begin
      hour24_nxt = (hour24 == 5'd23) ? 5'd0 : hour24 + 5'd1;
    end

    if (adj_a && field == F_MIN)  al_min_nxt  = step6(al_min, 6'd59, step_up);
    if (adj_a && field == F_HOUR) al_hour_nxt = step5(al_hour, 5'd23, step_up);
  end

  // Only a natural tick roll onto hh:mm:00.0 fires; any adjust on the same
  // edge (time or alarm) suppresses the pulse.
  assign fire = alarm_en && tick && !adj &&
                (msec_nxt == 7'd0) && (sec_nxt == 6'd0) &&
                (min_nxt == al_min) && (hour24_nxt == al_hour);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      msec      <= 7'd0;
      sec       <= 6'd0;
      min       <= 6'd0;
      hour24    <= 5'd0;
      al_min    <= 6'd0;
      al_hour   <= 5'd0;
      alarm_hit <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      msec      <= msec_nxt;
      sec       <= sec_nxt;
      min       <= min_nxt;
      hour24    <= hour24_nxt;
      al_min    <= al_min_nxt;
      al_hour   <= al_hour_nxt;
      alarm_hit <= fire;
    end
  end

  always_comb begin
    hour = hour24;
    if (h12) begin
      if (hour24 == 5'd0)      hour = 5'd12;
      else if (hour24 > 5'd12) hour = hour24 - 5'd12;
      else                     hour = hour24;
    end
  end

  assign pm = (hour24 >= 5'd12);

endmodule

// File: tb/tb_watch_set_alarm.sv
// Directed bench for watch_set_alarm at CLK_HZ=1000, TICK_HZ=10 (one tick
// every 100 clocks). Outputs are sampled 1 time unit after the rising edge.

module tb_watch_set_alarm;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_dn;
  logic       set_en, target, h12, alarm_en;
  logic [1:0] field;
  logic [6:0] msec;
  logic [5:0] sec, min, al_min;
  logic [4:0] hour, al_hour;
  logic       pm, alarm_hit;

  int checks = 0;
  int errors = 0;

  watch_set_alarm #(.CLK_HZ(1000), .TICK_HZ(10), .DIV_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .btnU_up   (btn_up),
    .btnD_down (btn_dn),
    .set_en    (set_en),
    .target    (target),
    .field     (field),
    .h12       (h12),
    .alarm_en  (alarm_en),
    .msec      (msec),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .pm        (pm),
    .al_min    (al_min),
    .al_hour   (al_hour),
    .alarm_hit (alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // One button pulse lasting exactly one rising edge.
  task automatic pulse(input logic u, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_up = u;
      btn_dn = d;
      @(posedge clk);
      #1;
      btn_up = 1'b0;
      btn_dn = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    set_en = 1'b0; target = 1'b0; field = 2'b11; h12 = 1'b0; alarm_en = 1'b0;
    #12;
    chk("rst_msec", 32'(msec), 0);
    chk("rst_sec", 32'(sec), 0);
    chk("rst_min", 32'(min), 0);
    chk("rst_hour24", 32'(hour), 0);
    chk("rst_pm", 32'(pm), 0);
    chk("rst_al", 32'({al_hour, al_min}), 0);
    chk("rst_hit", 32'(alarm_hit), 0);
    h12 = 1'b1; #1;
    chk("rst_hour12", 32'(hour), 12);
    h12 = 1'b0;

    // Free running time base
    @(negedge clk); rst = 1'b0;
    edges(99);
    chk("run_msec_99", 32'(msec), 0);
    edges(1);
    chk("run_msec_100", 32'(msec), 1);
    edges(100);
    chk("run_msec_200", 32'(msec), 2);
    edges(800);
    chk("run_sec_1000", 32'(sec), 1);
    chk("run_msec_1000", 32'(msec), 0);

    // Preload 23:59:59.9 and roll over in one edge
    set_en = 1'b1; target = 1'b0;
    field = 2'b10; pulse(1'b0, 1'b1, 1);
    chk("adj_hour_dn_wrap", 32'(hour), 23);
    field = 2'b01; pulse(1'b0, 1'b1, 1);
    chk("adj_min_dn_wrap", 32'(min), 59);
    field = 2'b00; pulse(1'b0, 1'b1, 2);
    chk("adj_sec_to_59", 32'(sec), 59);
    chk("adj_sec_clr_msec", 32'(msec), 0);
    field = 2'b11;
    edges(999);
    chk("pre_roll_msec", 32'(msec), 9);
    chk("pre_roll_pm", 32'(pm), 1);
    h12 = 1'b1; #1;
    chk("pre_roll_hour12", 32'(hour), 11);
    edges(1);
    chk("roll_time", 32'({hour, min, sec, msec}), 32'({5'd12, 6'd0, 6'd0, 7'd0}));
    chk("roll_pm", 32'(pm), 0);
    h12 = 1'b0; #1;
    chk("roll_hour24", 32'(hour), 0);

    // Sec down wrap without borrow; both buttons ignored
    field = 2'b00; pulse(1'b0, 1'b1, 1);
    chk("sec_dn_wrap", 32'(sec), 59);
    chk("sec_dn_no_borrow", 32'(min), 0);
    pulse(1'b1, 1'b1, 1);
    chk("both_btn_sec", 32'(sec), 59);
    chk("both_btn_min", 32'(min), 0);

    // Alarm hour via 13 ups; field 00 on alarm does nothing
    target = 1'b1; field = 2'b10; pulse(1'b1, 1'b0, 13);
    chk("al_hour_13", 32'(al_hour), 13);
    field = 2'b00; pulse(1'b1, 1'b0, 1); pulse(1'b0, 1'b1, 1);
    chk("al_sec_ign_al", 32'({al_hour, al_min}), 32'({5'd13, 6'd0}));
    chk("al_sec_ign_time", 32'({hour, min, sec}), 32'({5'd0, 6'd0, 6'd59}));

    // Alarm 07:30, time 07:29:59.9
    field = 2'b01; pulse(1'b1, 1'b0, 30);
    field = 2'b10; pulse(1'b0, 1'b1, 6);
    chk("al_set", 32'({al_hour, al_min}), 32'({5'd7, 6'd30}));
    target = 1'b0;
    field = 2'b10; pulse(1'b1, 1'b0, 7);
    field = 2'b01; pulse(1'b1, 1'b0, 29);
    field = 2'b00; pulse(1'b1, 1'b0, 1); pulse(1'b0, 1'b1, 1);
    field = 2'b11; alarm_en = 1'b1;
    edges(999);
    chk("al_pre_time", 32'({hour, min, sec, msec}), 32'({5'd7, 6'd29, 6'd59, 7'd9}));
    chk("al_pre_hit", 32'(alarm_hit), 0);
    edges(1);
    chk("al_roll_time", 32'({hour, min, sec, msec}), 32'({5'd7, 6'd30, 6'd0, 7'd0}));
    chk("al_hit_pulse", 32'(alarm_hit), 1);
    edges(1);
    chk("al_hit_one_cycle", 32'(alarm_hit), 0);

    // Same roll with alarm disabled
    alarm_en = 1'b0;
    field = 2'b01; pulse(1'b0, 1'b1, 1);
    field = 2'b00; pulse(1'b0, 1'b1, 1);
    field = 2'b11;
    edges(999);
    chk("dis_pre_time", 32'({hour, min, sec, msec}), 32'({5'd7, 6'd29, 6'd59, 7'd9}));
    edges(1);
    chk("dis_roll_time", 32'({min, sec}), 32'({6'd30, 6'd0}));
    chk("dis_no_hit", 32'(alarm_hit), 0);
    edges(1);
    chk("dis_no_hit_late", 32'(alarm_hit), 0);

    // Manual adjust onto a match must not fire
    alarm_en = 1'b1;
    field = 2'b01; pulse(1'b0, 1'b1, 1); pulse(1'b1, 1'b0, 1);
    chk("man_match_time", 32'({hour, min, sec}), 32'({5'd7, 6'd30, 6'd0}));
    edges(1);
    chk("man_match_no_hit", 32'(alarm_hit), 0);

    // Collision: tick carrying into sec while sec is adjusted
    field = 2'b00; pulse(1'b0, 1'b1, 1);
    field = 2'b11; edges(999);
    chk("col_pre", 32'({min, sec, msec}), 32'({6'd30, 6'd59, 7'd9}));
    field = 2'b00; pulse(1'b1, 1'b0, 1);
    chk("col_sec_msec", 32'({sec, msec}), 32'({6'd0, 7'd0}));
    chk("col_min_kept", 32'(min), 30);

    // 12:34:56, 12-hour display, then async reset between edges
    alarm_en = 1'b0; h12 = 1'b1;
    field = 2'b10; pulse(1'b1, 1'b0, 5);
    field = 2'b01; pulse(1'b1, 1'b0, 4);
    field = 2'b00; pulse(1'b0, 1'b1, 4);
    field = 2'b11; set_en = 1'b0;
    chk("pre_rst_time", 32'({hour, min, sec}), 32'({5'd12, 6'd34, 6'd56}));
    chk("pre_rst_pm", 32'(pm), 1);
    edges(50);
    rst = 1'b1; #1;
    chk("mid_rst_time", 32'({min, sec, msec}), 0);
    chk("mid_rst_hour12", 32'(hour), 12);
    chk("mid_rst_pm", 32'(pm), 0);
    chk("mid_rst_al", 32'({al_hour, al_min}), 0);
    chk("mid_rst_hit", 32'(alarm_hit), 0);
    @(negedge clk); rst = 1'b0;
    edges(2);
    chk("post_rst_sec", 32'(sec), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_set_alarm.md
Name: watch_set_alarm

Overview:
Parametrised real-time watch datapath and control. It is the next generation of the watch block. It keeps a sub-second/sec/min/hour time base from a prescaled system clock and lets the user adjust any single field up or down with wrap. It adds a selectable 12/24-hour display, an hour:minute alarm register set through the same buttons, and a one-cycle alarm pulse. It sits between the debounced button/switch front end and the FND/UART display formatters.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 100, sub-second tick rate. msec counts 0..TICK_HZ-1. Legal range 2..128; CLK_HZ must be an integer multiple of TICK_HZ.
DIV_W, 24, prescaler counter width. Must satisfy 2^DIV_W > CLK_HZ/TICK_HZ.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
btnU_up  input  1  debounced one-cycle pulse: increment the selected field.
btnD_down  input  1  debounced one-cycle pulse: decrement the selected field.
set_en  input  1  1 = adjust mode (buttons act); 0 = buttons ignored.
target  input  1  0 = adjust time, 1 = adjust alarm.
field  input  2  00 sec, 01 min, 10 hour, 11 none.
h12  input  1  1 = 12-hour display on hour output.
alarm_en  input  1  enables alarm_hit generation.
msec  output  7  sub-second count.
sec  output  6  seconds 0..59.
min  output  6  minutes 0..59.
hour  output  5  display hour: 0..23, or 1..12 when h12=1.
pm  output  1  1 when internal 24-h hour >= 12, regardless of h12.
al_min  output  6  alarm minute.
al_hour  output  5  alarm hour, always 24-h, 0..23.
alarm_hit  output  1  one-cycle pulse on alarm match.

Behaviour:
- Reset (async, immediate): prescaler, msec, sec, min and internal hour24 all 0; al_min=0, al_hour=0; alarm_hit=0. hour output = 0 if h12=0, 12 if h12=1. pm=0.
- Prescaler counts 0..CLK_HZ/TICK_HZ-1. On the terminal count it wraps to 0 and asserts an internal tick for 1 cycle.
- Time chain on tick:
  - msec increments; at TICK_HZ-1 it wraps to 0 and carries into sec.
  - sec wraps 59->0 and carries into min.
  - min wraps 59->0 and carries into hour24.
  - hour24 wraps 23->0.
  - All updates are registered in the same clock cycle; a full rollover 23:59:59.(TICK_HZ-1) -> 00:00:00.00 happens in one edge.
- Adjust: an edge is a valid adjust when set_en=1, field!=11, and exactly one of btnU_up/btnD_down is high. Both high together: no action.
  - target=0, time field: ±1 with wrap inside the field's own range (59<->0, 23<->0). No carry or borrow into neighbouring fields.
  - Adjusting sec also clears msec and the prescaler to 0.
  - Adjusting hour in 12-h display still steps hour24 by 1.
  - target=1: field=01 steps al_min (59<->0); field=10 steps al_hour (23<->0); field=00 is ignored.
- Same-cycle collision: if a time adjust and a natural carry hit the same field on one edge, the adjust result wins and the carry into that field is dropped. Lower fields still roll normally. Example: sec=59, msec=TICK_HZ-1, tick, up on sec -> sec=0, msec=0, min unchanged.
- Time keeps running in adjust mode. set_en does not freeze the count.
- 12-h mapping (combinational from hour24): 0->12, 1..11->same, 12->12, 13..23->hour24-12.
- Alarm:
  - alarm_hit=1 for exactly one cycle, on the cycle after the edge where the time chain advances to hour24==al_hour, min==al_min, sec==0, msec==0, provided alarm_en=1.
  - Manually setting the time or alarm onto a match does not fire.
  - alarm_en deasserted suppresses the pulse; no pending state is kept.
- Reset mid-operation aborts everything immediately. There is no partial state.

Test Plan:
1. CLK_HZ=1000, TICK_HZ=10. Release reset, run 100 clks -> msec=0..9 stepping every 100 clks, sec=1 at clk 1000.
2. Preload via adjust 23:59:59 with msec at 9, apply one tick -> 00:00:00.0 in a single edge, pm 1->0; with h12=1, hour 11->12.
3. set_en=1, field=00, sec=0, pulse btnD_down -> sec=59 and min unchanged; then btnU_up and btnD_down together -> no change.
4. target=1, field=10, 13 btnU_up pulses -> al_hour=13; field=00 pulses -> no change to any alarm or time register.
5. Alarm 07:30, alarm_en=1, run from 07:29:59.9 -> alarm_hit high exactly 1 cycle after rollover to 07:30:00.0; repeat with alarm_en=0 -> no pulse.
6. Assert rst while counting at 12:34:56 with h12=1 -> all counters 0 and hour=12 without waiting for a clock edge; al_* = 0.
